// File: rtl/readout_ctrl_pkg.sv
// Shared types and constants for the logic-analyzer capture/readout sequencer.
package readout_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    RD_ADDR,
    RD_LOAD,
    SEND
  } rdout_state_t;

  // Read and delay counts are programmed in units of four samples.
  localparam int CNT_MUL = 4;

  // SUMP "set read & delay count" opcode, decoded upstream into cfg_stb_i.
  localparam logic [7:0] SUMP_OP_SET_COUNTS = 8'h81;

endpackage

// File: rtl/readout_ctrl_ring_ptr.sv
// Wrapping up/down RAM pointer with parallel load; load has priority over count.
module readout_ctrl_ring_ptr #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i && !dec_i) begin
      ptr_d = ptr_q + W'(1);
    end else if (dec_i && !inc_i) begin
      ptr_d = ptr_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/readout_ctrl.sv
// Capture/readout sequencer: fills an external ring buffer while armed, counts
// post-trigger samples, then streams the newest samples out newest-first.
module readout_ctrl
  import readout_ctrl_pkg::*;
#(
  parameter int SMPL_W  = 32,
  parameter int DEPTH_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_stb_i,
  input  logic [CNT_W-1:0]   read_cnt_i,
  input  logic [CNT_W-1:0]   delay_cnt_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic               trg_i,
  input  logic               smpl_stb_i,
  input  logic [SMPL_W-1:0]  smpl_i,
  output logic               mem_we_o,
  output logic [DEPTH_W-1:0] mem_addr_o,
  output logic [SMPL_W-1:0]  mem_wdata_o,
  input  logic [SMPL_W-1:0]  mem_rdata_i,
  input  logic               tx_rdy_i,
  output logic               tx_stb_o,
  output logic [SMPL_W-1:0]  tx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int LEFT_W = CNT_W + 2;
  // One extra bit so 4*(read_cnt+1) cannot overflow before the clamp.
  localparam int PROD_W = CNT_W + 3;
  localparam logic [PROD_W-1:0] BUF_DEPTH = PROD_W'(1) << DEPTH_W;

  rdout_state_t       state_q, state_d;
  logic [CNT_W-1:0]   read_cnt_q, delay_cnt_q;
  logic [LEFT_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [LEFT_W-1:0]  rd_left_q, rd_left_d;
  logic [SMPL_W-1:0]  tx_q, tx_d;
  logic               done_q, done_d;

  logic [DEPTH_W-1:0] wr_ptr, rd_ptr, rd_start;
  logic               capturing, wr_en, wr_clr, rd_load, rd_dec;
  logic [PROD_W-1:0]  rd_req;
  logic [LEFT_W-1:0]  rd_total, dly_total;

  assign capturing = (state_q == ARMED) || (state_q == DELAY);
  assign wr_en     = capturing && smpl_stb_i;

  assign rd_req    = (PROD_W'(read_cnt_q) + PROD_W'(1)) * PROD_W'(CNT_MUL);
  assign rd_total  = LEFT_W'((rd_req > BUF_DEPTH) ? BUF_DEPTH : rd_req);
  assign dly_total = LEFT_W'(delay_cnt_q) * LEFT_W'(CNT_MUL);

  // Newest sample is the one written this cycle, else the one just before wr_ptr.
  assign rd_start  = wr_en ? wr_ptr : (wr_ptr - DEPTH_W'(1));

  readout_ctrl_ring_ptr #(.W(DEPTH_W)) u_wr_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (wr_clr),
    .load_val_i ('0),
    .inc_i      (wr_en),
    .dec_i      (1'b0),
    .ptr_o      (wr_ptr)
  );

  readout_ctrl_ring_ptr #(.W(DEPTH_W)) u_rd_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (rd_load),
    .load_val_i (rd_start),
    .inc_i      (1'b0),
    .dec_i      (rd_dec),
    .ptr_o      (rd_ptr)
  );

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    rd_left_d = rd_left_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    wr_clr    = 1'b0;
    rd_load   = 1'b0;
    rd_dec    = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d = ARMED;
            wr_clr  = 1'b1;
          end
        end
        ARMED: begin
          if (trg_i) begin
            if (delay_cnt_q == '0) begin
              state_d   = RD_ADDR;
              rd_load   = 1'b1;
              rd_left_d = rd_total;
            end else begin
              state_d   = DELAY;
              dly_cnt_d = dly_total;
            end
          end
        end
        DELAY: begin
          if (wr_en) begin
            dly_cnt_d = dly_cnt_q - LEFT_W'(1);
            if (dly_cnt_q == LEFT_W'(1)) begin
              state_d   = RD_ADDR;
              rd_load   = 1'b1;
              rd_left_d = rd_total;
            end
          end
        end
        RD_ADDR: state_d = RD_LOAD;
        RD_LOAD: begin
          tx_d    = mem_rdata_i;
          state_d = SEND;
        end
        SEND: begin
          if (tx_rdy_i) begin
            rd_dec    = 1'b1;
            rd_left_d = rd_left_q - LEFT_W'(1);
            if (rd_left_q == LEFT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RD_ADDR;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      read_cnt_q  <= '0;
      delay_cnt_q <= '0;
      dly_cnt_q   <= '0;
      rd_left_q   <= '0;
      tx_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      rd_left_q <= rd_left_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      if (cfg_stb_i && (state_q == IDLE)) begin
        read_cnt_q  <= read_cnt_i;
        delay_cnt_q <= delay_cnt_i;
      end
    end
  end

  assign mem_we_o    = wr_en;
  assign mem_addr_o  = (state_q == RD_ADDR) ? rd_ptr : wr_ptr;
  assign mem_wdata_o = wr_en ? smpl_i : '0;
  assign tx_stb_o    = (state_q == SEND);
  assign tx_o        = tx_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_readout_ctrl.sv
// Self-checking bench for readout_ctrl: directed scenarios plus randomized captures
// compared against a sample-history model of the ring buffer.
module tb_readout_ctrl;

  localparam int SMPL_W  = 32;
  localparam int DEPTH_W = 4;
  localparam int CNT_W   = 16;
  localparam int DEPTH   = 1 << DEPTH_W;

  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic               cfg_stb_i = 1'b0;
  logic [CNT_W-1:0]   read_cnt_i = '0;
  logic [CNT_W-1:0]   delay_cnt_i = '0;
  logic               arm_i = 1'b0;
  logic               abort_i = 1'b0;
  logic               trg_i = 1'b0;
  logic               smpl_stb_i = 1'b0;
  logic [SMPL_W-1:0]  smpl_i = '0;
  logic               mem_we_o;
  logic [DEPTH_W-1:0] mem_addr_o;
  logic [SMPL_W-1:0]  mem_wdata_o;
  logic [SMPL_W-1:0]  mem_rdata_i;
  logic               tx_rdy_i = 1'b0;
  logic               tx_stb_o;
  logic [SMPL_W-1:0]  tx_o;
  logic               busy_o;
  logic               done_o;

  always #5 clk = ~clk;

  readout_ctrl #(.SMPL_W(SMPL_W), .DEPTH_W(DEPTH_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cfg_stb_i   (cfg_stb_i),
    .read_cnt_i  (read_cnt_i),
    .delay_cnt_i (delay_cnt_i),
    .arm_i       (arm_i),
    .abort_i     (abort_i),
    .trg_i       (trg_i),
    .smpl_stb_i  (smpl_stb_i),
    .smpl_i      (smpl_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .tx_rdy_i    (tx_rdy_i),
    .tx_stb_o    (tx_stb_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // External single-port RAM, 1-cycle read latency.
  logic [SMPL_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  // Reference: value last written into each buffer slot, by write index since arm.
  logic [SMPL_W-1:0] ref_mem [DEPTH];
  logic [SMPL_W-1:0] rx_q [$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rdy_prob = 100;
  int bp_left = 0;
  bit mon_chk_en = 1'b1;

  task automatic chk(input string tag, input logic [SMPL_W-1:0] obs, input logic [SMPL_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transmitter model: chooses tx_rdy_i, records transfers, counts done pulses,
  // and checks tx_o stays stable while a word is being held off.
  initial begin
    logic             was_wait;
    logic [SMPL_W-1:0] held;
    was_wait = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        was_wait = 1'b0;
        tx_rdy_i = 1'b0;
      end else begin
        if (tx_stb_o && bp_left > 0) begin
          tx_rdy_i = 1'b0;
          bp_left--;
        end else begin
          tx_rdy_i = ($urandom_range(99) < rdy_prob);
        end
        if (was_wait && mon_chk_en) begin
          chk("hold_stb", {31'd0, tx_stb_o}, 32'd1);
          chk("hold_data", tx_o, held);
        end
        if (tx_stb_o && tx_rdy_i) begin
          rx_q.push_back(tx_o);
          $display("tx word %h", tx_o);
        end
        was_wait = tx_stb_o && !tx_rdy_i;
        held = tx_o;
        if (done_o) done_cnt++;
      end
    end
  end

  task automatic configure(input int rc, input int dc);
    @(negedge clk);
    cfg_stb_i = 1'b1;
    read_cnt_i = CNT_W'(rc);
    delay_cnt_i = CNT_W'(dc);
    @(negedge clk);
    cfg_stb_i = 1'b0;
  endtask

  task automatic arm();
    @(negedge clk);
    arm_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
  endtask

  // Drives strobed samples until 'stop' writes have been made, triggering on write t,
  // then 'extra' strobes that must not reach the RAM.
  task automatic stream(input int t, input int stop, input bit seq, input int gap, input int extra);
    int w;
    w = 0;
    while (w < stop) begin
      @(negedge clk);
      smpl_stb_i = ($urandom_range(99) >= gap);
      smpl_i = seq ? SMPL_W'(w) : SMPL_W'($urandom);
      trg_i = smpl_stb_i && (w == t);
      if (smpl_stb_i) begin
        ref_mem[w % DEPTH] = smpl_i;
        w++;
      end
    end
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      trg_i = 1'b0;
      smpl_stb_i = 1'b1;
      smpl_i = SMPL_W'($urandom);
      #1;
      chk("no_write_after_capture", {31'd0, mem_we_o}, 32'd0);
    end
    @(negedge clk);
    smpl_stb_i = 1'b0;
    trg_i = 1'b0;
  endtask

  task automatic check_readout(input string tag, input int rc, input int s);
    int n;
    int idx;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = (done_cnt != 0);
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    n = 4 * (rc + 1);
    if (n > DEPTH) n = DEPTH;
    chk({tag, "_count"}, SMPL_W'(rx_q.size()), SMPL_W'(n));
    for (int k = 0; k < n && k < rx_q.size(); k++) begin
      idx = ((s - 1 - k) % DEPTH + DEPTH) % DEPTH;
      chk($sformatf("%s_word%0d", tag, k), rx_q[k], ref_mem[idx]);
    end
    chk({tag, "_done_once"}, SMPL_W'(done_cnt), 32'd1);
    chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    $display("capture %s: rc=%0d writes=%0d words=%0d", tag, rc, s, rx_q.size());
  endtask

  task automatic run_capture(input string tag, input int rc, input int dc, input int t,
                             input bit seq, input int gap, input int prob, input int bp, input int extra);
    configure(rc, dc);
    rx_q.delete();
    done_cnt = 0;
    rdy_prob = prob;
    bp_left = bp;
    arm();
    stream(t, t + 1 + 4 * dc, seq, gap, extra);
    check_readout(tag, rc, t + 1 + 4 * dc);
  endtask

  task automatic wait_send(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = tx_stb_o;
    end
    chk({tag, "_reached_send"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_stb", {31'd0, tx_stb_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_tx", tx_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Basic: samples 0..9, trigger on 9, four newest words out.
    run_capture("basic", 0, 0, 9, 1'b1, 0, 100, 0, 3);

    // Post-trigger delay with pointer wrap: 0x00..0x0F written, 0x0F..0x08 read.
    run_capture("delay_wrap", 1, 1, 11, 1'b1, 0, 100, 0, 4);

    // Backpressure: first word held off for five cycles.
    run_capture("backpressure", 1, 0, 5, 1'b0, 0, 100, 5, 0);

    // Read count larger than the buffer is clamped to its depth.
    run_capture("clamp", 7, 0, 40, 1'b0, 20, 100, 0, 0);

    // Counts loaded while armed are ignored; the old ones (rc=0, dc=0) apply.
    configure(0, 0);
    rx_q.delete();
    done_cnt = 0;
    rdy_prob = 100;
    arm();
    @(negedge clk);
    cfg_stb_i = 1'b1;
    read_cnt_i = 16'd3;
    delay_cnt_i = 16'd2;
    @(negedge clk);
    cfg_stb_i = 1'b0;
    stream(6, 7, 1'b0, 0, 0);
    check_readout("cfg_in_armed", 0, 7);

    // Abort while counting post-trigger samples.
    mon_chk_en = 1'b0;
    configure(0, 3);
    rx_q.delete();
    done_cnt = 0;
    arm();
    stream(2, 6, 1'b0, 0, 0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_delay_idle", {31'd0, busy_o}, 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_delay_no_done", SMPL_W'(done_cnt), 32'd0);
    chk("abort_delay_no_tx", SMPL_W'(rx_q.size()), 32'd0);

    // Abort while a word is offered.
    configure(1, 0);
    done_cnt = 0;
    rdy_prob = 0;
    arm();
    stream(3, 4, 1'b0, 0, 0);
    wait_send("abort_send");
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_send_stb", {31'd0, tx_stb_o}, 32'd0);
    chk("abort_send_idle", {31'd0, busy_o}, 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_send_no_done", SMPL_W'(done_cnt), 32'd0);

    // Asynchronous reset in the middle of SEND.
    arm();
    stream(1, 2, 1'b0, 0, 0);
    wait_send("rst_send");
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_send_stb", {31'd0, tx_stb_o}, 32'd0);
    chk("rst_send_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_send_we", {31'd0, mem_we_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    mon_chk_en = 1'b1;

    // Randomized captures with sample gaps and transmitter stalls.
    for (int r = 0; r < 8; r++) begin
      run_capture($sformatf("rand%0d", r), $urandom_range(0, 4), $urandom_range(0, 2),
                  $urandom_range(0, 25), 1'b0, 30, 60, 0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
